detect_rate_monitor: RTL and testbench
======================================

DETECT_RATE_MONITOR -- requirements
Module: detect_rate_monitor

Interface
REQ-001 Parameters SHALL be, one per line:
- CNT_WIDTH, 8, width of all detection counters
- WIN_WIDTH, 16, width of the window-length input and internal window timer
REQ-002 Ports SHALL be, one per line:
- clk  input  1  single system clock; all state updates on its rising edge
- rst  input  1  reset, synchronous, active-high
- enable  input  1  monitoring enable; level-sensitive
- det  input  1  registered match output of the upstream Moore sequence detector; one count per cycle det=1
- win_len  input  WIN_WIDTH  window length in cycles; sampled only at window start
- threshold  input  CNT_WIDTH  alarm threshold; sampled at window end
- clear  input  1  synchronous clear of total_count, alarm, overflow
- win_count  output  CNT_WIDTH  detections in the last completed window
- win_done  output  1  one-cycle pulse: win_count just updated
- total_count  output  CNT_WIDTH  detections since reset/clear, saturating
- alarm  output  1  sticky: a completed window reached threshold
- overflow  output  1  sticky: total_count saturated and another detection arrived

Function
REQ-003 FSM SHALL have two states, IDLE and COUNT; all outputs registered.
REQ-004 IDLE -> COUNT when enable=1 and win_len!=0; timer loads win_len, window accumulator loads 0; no det sampling in this transition cycle.
REQ-005 IDLE with enable=1 and win_len=0 SHALL remain IDLE.
REQ-006 COUNT: each cycle sample det into accumulator (saturating at 2^CNT_WIDTH-1) and decrement timer.
REQ-007 Window end = COUNT cycle with timer==1; window SHALL contain exactly win_len sampled cycles, including the end cycle's det.
REQ-008 At window end: win_count <= final accumulator (incl. end-cycle det), win_done=1 in the following cycle only; latency 1 cycle from last sample.
REQ-009 At window end with enable=1 and win_len!=0: reload timer from current win_len, clear accumulator, stay COUNT (back-to-back windows, no sampling gap); otherwise go IDLE.
REQ-010 enable=0 in COUNT SHALL abort: accumulator discarded, no win_done, win_count holds, next state IDLE; that cycle's det not counted.
REQ-011 total_count SHALL increment for each det=1 cycle sampled in COUNT, saturating at 2^CNT_WIDTH-1; no wrap-around.
REQ-012 overflow SHALL set when det=1 is sampled with total_count already at maximum.
REQ-013 alarm SHALL set at window end when threshold!=0 and final window count >= threshold; threshold=0 never alarms.
REQ-014 clear=1: total_count, alarm, overflow cleared that cycle; window state, win_count unaffected.
REQ-015 clear with simultaneous det sample: total_count becomes 1 (event not lost); clear with simultaneous alarm-setting window end: alarm=1 (set wins); same for overflow.
REQ-016 win_len, threshold changes mid-window SHALL have no effect until next sample point (window start / window end respectively).

Reset
REQ-017 rst=1 at a rising edge SHALL force state IDLE, timer 0, accumulator 0, and win_count, win_done, total_count, alarm, overflow all 0, overriding every other input.
REQ-018 rst asserted mid-window SHALL discard the window; no win_done is produced for it after release.
REQ-019 After rst deasserts, first window starts per REQ-004 no earlier than the next cycle.

Verification
REQ-020 Bench SHALL cover these directed scenarios:
- rst=1 for 2 cycles with enable=1, det=1 -> all outputs 0 during and 1 cycle after release; no counts.
- win_len=8, threshold=2, det=1 in window cycles 3 and 6 -> win_count=2, win_done one cycle after cycle 8, alarm=1, total_count=2.
- win_len=4, det=1 constantly, 3 windows -> win_done every 4 cycles, win_count=4 each, total_count=12, no gap samples lost.
- CNT_WIDTH=8, win_len=1000, det=1 for 300 cycles -> total_count=255, overflow=1, win_count=255 at window end.
- win_len=8, enable dropped in window cycle 5 -> no win_done, win_count keeps prior value, state IDLE.
- clear coincident with det=1 and with alarm-setting window end -> total_count=1, alarm=1; clear alone next cycle -> alarm=0, total_count=0.

Source files
------------

// File: rtl/detect_rate_monitor.sv
// Counts detector hits per programmable window, plus a saturating running total with sticky alarm/overflow.
// Latency: win_count/win_done one cycle after the last window sample. No backpressure; det is sampled every COUNT cycle.
module detect_rate_monitor #(
    parameter int CNT_WIDTH = 8,
    parameter int WIN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 det,
    input  logic [WIN_WIDTH-1:0] win_len,
    input  logic [CNT_WIDTH-1:0] threshold,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] win_count,
    output logic                 win_done,
    output logic [CNT_WIDTH-1:0] total_count,
    output logic                 alarm,
    output logic                 overflow
);

    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                 state;
    logic [WIN_WIDTH-1:0]   timer;
    logic [CNT_WIDTH-1:0]   acc;

    logic                   samp;
    logic                   hit;
    logic                   win_end;
    logic                   alarm_set;
    logic                   ovf_set;
    logic [CNT_WIDTH-1:0]   acc_next;
    logic [CNT_WIDTH-1:0]   total_next;

    always_comb begin
        samp       = (state == COUNT) && enable;
        hit        = samp && det;
        acc_next   = (hit && acc != CNT_MAX) ? acc + CNT_WIDTH'(1) : acc;
        win_end    = samp && (timer == WIN_WIDTH'(1));
        alarm_set  = win_end && (threshold != '0) && (acc_next >= threshold);
        ovf_set    = hit && (total_count == CNT_MAX);
        // Clear and a same-cycle hit: the hit survives as a count of one.
        total_next = clear ? '0 : total_count;
        if (hit && total_next != CNT_MAX) begin
            total_next = total_next + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            acc         <= '0;
            win_count   <= '0;
            win_done    <= 1'b0;
            total_count <= '0;
            alarm       <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            win_done    <= 1'b0;
            total_count <= total_next;
            alarm       <= (clear ? 1'b0 : alarm) | alarm_set;
            overflow    <= (clear ? 1'b0 : overflow) | ovf_set;

            case (state)
                IDLE: begin
                    if (enable && win_len != '0) begin
                        state <= COUNT;
                        timer <= win_len;
                        acc   <= '0;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        state <= IDLE;
                        timer <= '0;
                        acc   <= '0;
                    end else if (win_end) begin
                        win_count <= acc_next;
                        win_done  <= 1'b1;
                        acc       <= '0;
                        // Back-to-back windows: reload without a gap cycle.
                        if (win_len != '0) begin
                            timer <= win_len;
                        end else begin
                            state <= IDLE;
                            timer <= '0;
                        end
                    end else begin
                        timer <= timer - WIN_WIDTH'(1);
                        acc   <= acc_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                    acc   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_detect_rate_monitor.sv
// Directed bench for detect_rate_monitor; expected values are hand-computed per scenario.
module tb_detect_rate_monitor;

    logic        tb_clk;
    logic        rst;
    logic        enable;
    logic        det;
    logic [15:0] win_len;
    logic [7:0]  threshold;
    logic        clear;
    logic [7:0]  win_count;
    logic        win_done;
    logic [7:0]  total_count;
    logic        alarm;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    detect_rate_monitor #(.CNT_WIDTH(8), .WIN_WIDTH(16)) dut (
        .clk         (tb_clk),
        .rst         (rst),
        .enable      (enable),
        .det         (det),
        .win_len     (win_len),
        .threshold   (threshold),
        .clear       (clear),
        .win_count   (win_count),
        .win_done    (win_done),
        .total_count (total_count),
        .alarm       (alarm),
        .overflow    (overflow)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; det = 1'b0; clear = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wc"}, 32'(win_count), 0);
        chk({tag, "_wd"}, 32'(win_done), 0);
        chk({tag, "_tot"}, 32'(total_count), 0);
        chk({tag, "_alm"}, 32'(alarm), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
    endtask

    initial begin
        // Reset held with enable and det active.
        rst = 1'b1; enable = 1'b1; det = 1'b1; clear = 1'b0;
        win_len = 16'd8; threshold = 8'd1;
        tick();
        chk_zero("rst1");
        tick();
        chk_zero("rst2");
        rst = 1'b0;
        tick();
        chk_zero("rel1");
        enable = 1'b0; det = 1'b0;
        tick();
        chk("rel_abort_tot", 32'(total_count), 0);
        chk("rel_abort_wd", 32'(win_done), 0);

        // Window of 8, hits in cycles 3 and 6, threshold 2.
        do_reset();
        win_len = 16'd8; threshold = 8'd2; enable = 1'b1; det = 1'b0;
        tick();
        for (int i = 1; i <= 8; i++) begin
            det = (i == 3 || i == 6);
            tick();
            if (i == 7) begin
                chk("w8_pre_wd", 32'(win_done), 0);
                chk("w8_pre_alm", 32'(alarm), 0);
            end
        end
        chk("w8_wc", 32'(win_count), 2);
        chk("w8_wd", 32'(win_done), 1);
        chk("w8_alm", 32'(alarm), 1);
        chk("w8_tot", 32'(total_count), 2);
        enable = 1'b0; det = 1'b0;
        tick();
        chk("w8_wd_drop", 32'(win_done), 0);

        // Three back-to-back windows of 4 with det held high, threshold 0.
        do_reset();
        win_len = 16'd4; threshold = 8'd0; enable = 1'b1; det = 1'b1;
        tick();
        for (int w = 0; w < 3; w++) begin
            for (int c = 1; c <= 4; c++) begin
                tick();
                chk($sformatf("b2b_wd_%0d_%0d", w, c), 32'(win_done), (c == 4) ? 1 : 0);
                if (c == 4) chk($sformatf("b2b_wc_%0d", w), 32'(win_count), 4);
            end
        end
        chk("b2b_tot", 32'(total_count), 12);
        chk("b2b_alm_thr0", 32'(alarm), 0);

        // Saturation: 1000-cycle window, 300 hits.
        do_reset();
        win_len = 16'd1000; threshold = 8'd0; enable = 1'b1; det = 1'b1;
        tick();
        for (int i = 1; i <= 1000; i++) begin
            det = (i <= 300);
            tick();
            if (i == 255) begin
                chk("sat_tot255", 32'(total_count), 255);
                chk("sat_ovf255", 32'(overflow), 0);
            end
            if (i == 256) chk("sat_ovf256", 32'(overflow), 1);
            if (i == 300) chk("sat_tot300", 32'(total_count), 255);
            if (i == 999) chk("sat_wd999", 32'(win_done), 0);
        end
        chk("sat_wc", 32'(win_count), 255);
        chk("sat_wd", 32'(win_done), 1);
        chk("sat_ovf", 32'(overflow), 1);
        chk("sat_alm", 32'(alarm), 0);
        clear = 1'b1; det = 1'b1;
        tick();
        chk("sat_clr_tot", 32'(total_count), 1);
        chk("sat_clr_ovf", 32'(overflow), 1);
        det = 1'b0;
        tick();
        chk("sat_clr2_tot", 32'(total_count), 0);
        chk("sat_clr2_ovf", 32'(overflow), 0);
        clear = 1'b0;

        // Abort: full window of 8 hits, then enable dropped in cycle 5 of the next.
        do_reset();
        win_len = 16'd8; threshold = 8'd0; enable = 1'b1; det = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) tick();
        chk("ab_wc_first", 32'(win_count), 8);
        for (int i = 1; i <= 4; i++) tick();
        enable = 1'b0;
        tick();
        chk("ab_wd", 32'(win_done), 0);
        chk("ab_wc_hold", 32'(win_count), 8);
        chk("ab_tot", 32'(total_count), 12);
        for (int i = 0; i < 4; i++) tick();
        chk("ab_idle_wd", 32'(win_done), 0);
        chk("ab_idle_tot", 32'(total_count), 12);
        enable = 1'b1; det = 1'b0;
        tick();
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) chk("ab_restart_wd7", 32'(win_done), 0);
        end
        chk("ab_restart_wd8", 32'(win_done), 1);
        chk("ab_restart_wc", 32'(win_count), 0);

        // Clear coincident with a hit and an alarm-setting window end.
        do_reset();
        win_len = 16'd4; threshold = 8'd2; enable = 1'b1; det = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) tick();
        chk("clr_pre_tot", 32'(total_count), 3);
        clear = 1'b1;
        tick();
        chk("clr_tot", 32'(total_count), 1);
        chk("clr_alm", 32'(alarm), 1);
        chk("clr_wc", 32'(win_count), 4);
        enable = 1'b0; det = 1'b0;
        tick();
        chk("clr2_alm", 32'(alarm), 0);
        chk("clr2_tot", 32'(total_count), 0);
        chk("clr2_wc", 32'(win_count), 4);
        clear = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
